// File: rtl/module_fifo_datos_uart.sv
// ============================================================================
// Module      : module_fifo_datos_uart
// Description : UART TX data FIFO. Bus writes push characters and the TX FSM
//               pops them over valid/ready. Reports level, full and sticky
//               overflow, and supports a synchronous flush.
//               Optional macro UART_FIFO_ALMOST_FULL_EN adds almost_full_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_fifo_datos_uart #(
  parameter int BUS_W  = 32,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_TH  = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       we_i,
  input  logic [BUS_W-1:0]           data_i,
  input  logic                       flush_i,
  input  logic                       clr_ovf_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
`ifdef UART_FIFO_ALMOST_FULL_EN
  ,
  output logic                       almost_full_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic              overflow;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign pop   = !empty && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = we_i && (!full || pop);
  assign ovf_set = we_i && full && !pop && !flush_i;

  // Storage is intentionally left out of reset; data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= data_i[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
      end
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_ovf_i) overflow <= 1'b0;
    end
  end

  assign data_o     = empty ? '0 : mem[rd_ptr];
  assign valid_o    = !empty;
  assign full_o     = full;
  assign level_o    = level;
  assign overflow_o = overflow;

`ifdef UART_FIFO_ALMOST_FULL_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      almost_full_o <= 1'b0;
    end else begin
      almost_full_o <= (level >= LW'(AF_TH));
    end
  end
`else
  wire [31:0] unused_af_th = AF_TH;
`endif

  generate
    if (BUS_W > DATA_W) begin : g_unused_hi
      wire unused_hi = &{1'b0, data_i[BUS_W-1:DATA_W]};
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_module_fifo_datos_uart.sv
// Directed bench for module_fifo_datos_uart with default parameters (DEPTH=16).
`default_nettype none

module tb_module_fifo_datos_uart;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [7:0]  dout;
  logic        valid;
  logic        ready = 1'b0;
  logic        full;
  logic [4:0]  level;
  logic        ovf;
`ifdef UART_FIFO_ALMOST_FULL_EN
  logic        af;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  module_fifo_datos_uart dut (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .data_i(wdata),
    .flush_i(flush), .clr_ovf_i(clr_ovf), .data_o(dout), .valid_o(valid),
    .ready_i(ready), .full_o(full), .level_o(level), .overflow_o(ovf)
`ifdef UART_FIFO_ALMOST_FULL_EN
    , .almost_full_o(af)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    we = 1'b1;
    wdata = {24'hC0FFEE, b};
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({level, valid, full, ovf, dout} !== {5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got lvl=%0d v=%b f=%b o=%b d=%h expected all 0", level, valid, full, ovf, dout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
    push(8'hA1);
    n_checks++;
    if ({valid, level} !== {1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL basic_latency: got v=%b lvl=%0d expected v=1 lvl=1", valid, level);
    end
    push(8'hB2);
    push(8'hC3);
    n_checks++;
    if ({level, dout} !== {5'd3, 8'hA1}) begin
      n_fail++;
      $display("FAIL basic_level_head: got lvl=%0d d=%h expected lvl=3 d=a1", level, dout);
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({valid, dout} !== {1'b1, exp_b[i]}) begin
        n_fail++;
        $display("FAIL basic_pop%0d: got v=%b d=%h expected v=1 d=%h", i, valid, dout, exp_b[i]);
      end
      tick();
    end
    ready = 1'b0;
    n_checks++;
    if ({valid, level, dout} !== {1'b0, 5'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL basic_empty: got v=%b lvl=%0d d=%h expected v=0 lvl=0 d=00", valid, level, dout);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(8'(i));
    n_checks++;
    if ({full, level, ovf} !== {1'b1, 5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_full: got f=%b lvl=%0d o=%b expected f=1 lvl=16 o=0", full, level, ovf);
    end
    push(8'hFF);
    n_checks++;
    if ({full, level, ovf} !== {1'b1, 5'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_set: got f=%b lvl=%0d o=%b expected f=1 lvl=16 o=1", full, level, ovf);
    end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (dout !== 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got %h expected %h", i, dout, 8'(i));
      end
      tick();
    end
    ready = 1'b0;
    n_checks++;
    if ({valid, ovf} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sticky: got v=%b o=%b expected v=0 o=1", valid, ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    n_checks++;
    if (dout !== 8'h10) begin
      n_fail++;
      $display("FAIL fpp_head: got %h expected 10", dout);
    end
    we = 1'b1; wdata = 32'hFFFF_FF55; ready = 1'b1;
    tick();
    we = 1'b0;
    n_checks++;
    if ({level, full, ovf} !== {5'd16, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fpp_level: got lvl=%0d f=%b o=%b expected lvl=16 f=1 o=0", level, full, ovf);
    end
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h55 : 8'h10 + 8'(i);
      n_checks++;
      if (dout !== e) begin
        n_fail++;
        $display("FAIL fpp_drain%0d: got %h expected %h", i, dout, e);
      end
      tick();
    end
    ready = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_empty: got v=%b expected 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      we = 1'b1;
      wdata = {24'h123456, 8'h40 + 8'(i)};
      if (i > 0) begin
        n_checks++;
        if ({valid, dout, level} !== {1'b1, 8'h40 + 8'(i - 1), 5'd1}) begin
          n_fail++;
          $display("FAIL stream%0d: got v=%b d=%h lvl=%0d expected v=1 d=%h lvl=1", i, valid, dout, level, 8'h40 + 8'(i - 1));
        end
      end
      tick();
    end
    we = 1'b0;
    n_checks++;
    if (dout !== 8'h67) begin
      n_fail++;
      $display("FAIL stream_last: got %h expected 67", dout);
    end
    tick();
    ready = 1'b0;
    n_checks++;
    if ({valid, level} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL stream_empty: got v=%b lvl=%0d expected v=0 lvl=0", valid, level);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    flush = 1'b1; we = 1'b1; wdata = 32'h0000_0077;
    tick();
    flush = 1'b0; we = 1'b0;
    n_checks++;
    if ({level, valid, dout} !== {5'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL flush: got lvl=%0d v=%b d=%h expected lvl=0 v=0 d=00", level, valid, dout);
    end
    tick();
    n_checks++;
    if ({level, valid} !== {5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_no_store: got lvl=%0d v=%b expected lvl=0 v=0", level, valid);
    end
    for (int i = 0; i < 17; i++) push(8'(i));
    ready = 1'b1; we = 1'b1; wdata = 32'h0000_0099;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, valid, full, ovf, dout} !== {5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: got lvl=%0d v=%b f=%b o=%b d=%h expected all 0", level, valid, full, ovf, dout);
    end
    we = 1'b0; ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef UART_FIFO_ALMOST_FULL_EN
  task automatic test_almost_full();
    for (int i = 0; i < 11; i++) push(8'(i));
    tick();
    n_checks++;
    if (af !== 1'b0) begin
      n_fail++;
      $display("FAIL af_11: got %b expected 0", af);
    end
    push(8'h0B);
    n_checks++;
    if (af !== 1'b0) begin
      n_fail++;
      $display("FAIL af_lag: got %b expected 0", af);
    end
    tick();
    n_checks++;
    if (af !== 1'b1) begin
      n_fail++;
      $display("FAIL af_12: got %b expected 1", af);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    n_checks++;
    if ({af, level} !== {1'b0, 5'd11}) begin
      n_fail++;
      $display("FAIL af_pop: got af=%b lvl=%0d expected af=0 lvl=11", af, level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_flush_reset();
`ifdef UART_FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
